// File: rtl/parking_pkg.sv
// +--------------------------------------------------------------------+
// | parking_pkg : shared types and sensor encodings for the parking    |
// | lot counter.                                          Rev 1.0      |
// +--------------------------------------------------------------------+
`default_nettype none

package parking_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      EN1    = 3'd1,
      EN2    = 3'd2,
      EN3    = 3'd3,
      EX1    = 3'd4,
      EX2    = 3'd5,
      EX3    = 3'd6,
      RESYNC = 3'd7
   } gate_state_t;

   typedef enum logic [1:0] {
      EVT_NONE  = 2'd0,
      EVT_ENTER = 2'd1,
      EVT_EXIT  = 2'd2
   } gate_evt_t;

   // Sensor pair encodings, written as {outer, inner}
   localparam logic [1:0] S_CLEAR = 2'b00;
   localparam logic [1:0] S_OUTER = 2'b10;
   localparam logic [1:0] S_BOTH  = 2'b11;
   localparam logic [1:0] S_INNER = 2'b01;

endpackage

`default_nettype wire

// File: rtl/parking_gate_fsm.sv
// +--------------------------------------------------------------------+
// | parking_gate_fsm : classifies one gate's beam sequence as a car    |
// | entry or exit.                                        Rev 1.0      |
// +--------------------------------------------------------------------+
`default_nettype none

module parking_gate_fsm
   import parking_pkg::*;
(
   input  logic      clk,
   input  logic      reset,
   input  logic      outer,
   input  logic      inner,
   output logic      enter_pulse,
   output logic      exit_pulse,
   output gate_evt_t evt
);

   logic [1:0]  w_in;
   gate_state_t r_state;
   gate_state_t w_next;
   gate_evt_t   w_evt;
   logic        r_enter;
   logic        r_exit;

   assign w_in = {outer, inner};

   always_comb begin
      w_next = r_state;
      w_evt  = EVT_NONE;
      case (r_state)
         IDLE: begin
            case (w_in)
               S_OUTER: w_next = EN1;
               S_INNER: w_next = EX1;
               S_BOTH:  w_next = RESYNC;
               default: w_next = IDLE;
            endcase
         end
         EN1: begin
            case (w_in)
               S_OUTER: w_next = EN1;
               S_BOTH:  w_next = EN2;
               S_CLEAR: w_next = IDLE;
               default: w_next = RESYNC;
            endcase
         end
         EN2: begin
            case (w_in)
               S_BOTH:  w_next = EN2;
               S_INNER: w_next = EN3;
               S_OUTER: w_next = EN1;
               default: w_next = RESYNC;
            endcase
         end
         EN3: begin
            case (w_in)
               S_INNER: w_next = EN3;
               S_BOTH:  w_next = EN2;
               S_CLEAR: begin
                  w_next = IDLE;
                  w_evt  = EVT_ENTER;
               end
               default: w_next = RESYNC;
            endcase
         end
         EX1: begin
            case (w_in)
               S_INNER: w_next = EX1;
               S_BOTH:  w_next = EX2;
               S_CLEAR: w_next = IDLE;
               default: w_next = RESYNC;
            endcase
         end
         EX2: begin
            case (w_in)
               S_BOTH:  w_next = EX2;
               S_OUTER: w_next = EX3;
               S_INNER: w_next = EX1;
               default: w_next = RESYNC;
            endcase
         end
         EX3: begin
            case (w_in)
               S_OUTER: w_next = EX3;
               S_BOTH:  w_next = EX2;
               S_CLEAR: begin
                  w_next = IDLE;
                  w_evt  = EVT_EXIT;
               end
               default: w_next = RESYNC;
            endcase
         end
         default: begin
            // Wait for a fully clear gate before trusting the sensors again
            w_next = (w_in == S_CLEAR) ? IDLE : RESYNC;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_enter <= 1'b0;
         r_exit  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_enter <= (w_evt == EVT_ENTER);
         r_exit  <= (w_evt == EVT_EXIT);
      end
   end

   assign enter_pulse = r_enter;
   assign exit_pulse  = r_exit;
   assign evt         = w_evt;

endmodule

`default_nettype wire

// File: rtl/parking_lot_counter_multi.sv
// +--------------------------------------------------------------------+
// | parking_lot_counter_multi : multi-gate saturating occupancy        |
// | counter. Optional macro SYNC_INPUTS_EN adds 2-flop input sync.     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module parking_lot_counter_multi
   import parking_pkg::*;
#(
   parameter  int NUM_GATES = 2,
   parameter  int CAPACITY  = 16,
   localparam int CNT_W     = $clog2(CAPACITY + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_GATES-1:0] outer,
   input  logic [NUM_GATES-1:0] inner,
   output logic [CNT_W-1:0]     car_count,
   output logic                 full,
   output logic                 empty,
   output logic [NUM_GATES-1:0] enter_pulse,
   output logic [NUM_GATES-1:0] exit_pulse,
   output logic                 count_err
);

   localparam int SW = CNT_W + 2;
   localparam logic signed [SW-1:0] c_cap_s = SW'(CAPACITY);

   logic [NUM_GATES-1:0] w_outer;
   logic [NUM_GATES-1:0] w_inner;

`ifdef SYNC_INPUTS_EN
   logic [NUM_GATES-1:0] r_outer_s1, r_outer_s2;
   logic [NUM_GATES-1:0] r_inner_s1, r_inner_s2;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_outer_s1 <= '0;
         r_outer_s2 <= '0;
         r_inner_s1 <= '0;
         r_inner_s2 <= '0;
      end else begin
         r_outer_s1 <= outer;
         r_outer_s2 <= r_outer_s1;
         r_inner_s1 <= inner;
         r_inner_s2 <= r_inner_s1;
      end
   end

   assign w_outer = r_outer_s2;
   assign w_inner = r_inner_s2;
`else
   assign w_outer = outer;
   assign w_inner = inner;
`endif

   gate_evt_t w_evt [NUM_GATES];

   generate
      for (genvar g = 0; g < NUM_GATES; g++) begin : g_gate
         parking_gate_fsm u_gate (
            .clk         (clk),
            .reset       (reset),
            .outer       (w_outer[g]),
            .inner       (w_inner[g]),
            .enter_pulse (enter_pulse[g]),
            .exit_pulse  (exit_pulse[g]),
            .evt         (w_evt[g])
         );
      end
   endgenerate

   logic [SW-1:0]        w_n_enter;
   logic [SW-1:0]        w_n_exit;
   logic signed [SW-1:0] w_sum;
   logic [CNT_W-1:0]     w_count_nxt;
   logic                 w_err_evt;
   logic [CNT_W-1:0]     r_count;
   logic                 r_err;

   always_comb begin
      w_n_enter = '0;
      w_n_exit  = '0;
      for (int g = 0; g < NUM_GATES; g++) begin
         if (w_evt[g] == EVT_ENTER) w_n_enter = w_n_enter + SW'(1);
         if (w_evt[g] == EVT_EXIT)  w_n_exit  = w_n_exit  + SW'(1);
      end
   end

   // Net all gates first, then clamp, so a simultaneous in/out at a limit is not an error
   always_comb begin
      w_sum       = $signed({2'b00, r_count}) + $signed(w_n_enter) - $signed(w_n_exit);
      w_count_nxt = w_sum[CNT_W-1:0];
      w_err_evt   = 1'b0;
      if (w_sum < 0) begin
         w_count_nxt = '0;
         w_err_evt   = 1'b1;
      end else if (w_sum > c_cap_s) begin
         w_count_nxt = CNT_W'(CAPACITY);
         w_err_evt   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= '0;
         r_err   <= 1'b0;
      end else begin
         r_count <= w_count_nxt;
         r_err   <= r_err | w_err_evt;
      end
   end

   assign car_count = r_count;
   assign count_err = r_err;
   assign full      = (r_count == CNT_W'(CAPACITY));
   assign empty     = (r_count == '0);

endmodule

`default_nettype wire

// File: doc/parking_lot_counter_multi.md
Name: parking_lot_counter_multi

Overview:
- Parametrised multi-gate parking-lot occupancy counter.
- Each gate has an outer and an inner beam sensor. A per-gate FSM classifies a complete car passage as an entry or an exit.
- A shared occupancy counter sums all gate events in the same cycle and exposes full/empty flags for the display and LED logic.
- Successor to the single-gate counter: adds N gates, configurable capacity, pedestrian/abort rejection and error reporting.

Parameters:
- NUM_GATES, 2, number of gates; each gate has one outer/inner sensor pair.
- CAPACITY, 16, maximum occupancy; the full flag asserts at this value.
- CNT_W, $clog2(CAPACITY+1), derived localparam; width of car_count.

Ports:
- clk  input  1  system clock (CLOCK_50 at top level)
- reset  input  1  synchronous, active-high reset
- outer  input  NUM_GATES  outer sensor per gate, 1 = beam blocked
- inner  input  NUM_GATES  inner sensor per gate, 1 = beam blocked
- car_count  output  CNT_W  current occupancy, 0..CAPACITY
- full  output  1  car_count == CAPACITY
- empty  output  1  car_count == 0
- enter_pulse  output  NUM_GATES  one-cycle pulse per completed entry
- exit_pulse  output  NUM_GATES  one-cycle pulse per completed exit
- count_err  output  1  sticky; set on an entry while full or an exit while empty

Behaviour:
- Reset, sampled on the clk edge: all gate FSMs to IDLE; car_count=0; empty=1; full=0; all pulses=0; count_err=0. Reset mid-passage discards the partial sequence.
- Per-gate FSM. Input notation is {outer,inner}. States: IDLE, EN1, EN2, EN3, EX1, EX2, EX3, RESYNC.
  - Entry path: IDLE -10-> EN1 -11-> EN2 -01-> EN3 -00-> IDLE, asserting enter_pulse.
  - Exit path: IDLE -01-> EX1 -11-> EX2 -10-> EX3 -00-> IDLE, asserting exit_pulse.
  - Holding the current input keeps the state.
  - One step backward (car reverses) is legal: EN2-10->EN1, EN3-11->EN2, EX2-01->EX1, EX3-11->EX2.
  - EN1-00 or EX1-00 returns to IDLE with no event; this covers pedestrians and abandoned entries.
  - Any other input, i.e. a skipped step, -> RESYNC. RESYNC -00-> IDLE with no event.
  - IDLE with 11 -> RESYNC.
- Pulse timing: pulses are registered. Sampling 00 in EN3/EX3 at edge k drives the pulse high for the cycle after edge k.
- Counter update: at the same edge k, car_count <= car_count + E - X, where E and X are popcounts of this cycle's entry and exit completions across all gates. Arithmetic uses CNT_W+2 signed width.
- Saturation: the result is clamped to 0..CAPACITY. If the unclamped value exceeds CAPACITY or goes below 0, count_err <= 1. Pulses still fire.
- Simultaneous entry and exit on different gates net out first, then clamp. Example: full, +1 -1 -> stays CAPACITY, no error.
- full and empty are combinational from the registered car_count.
- No outputs depend combinationally on outer/inner.

Optional Feature:
- Macro SYNC_INPUTS_EN.
- Defined: outer and inner pass through a two-flop synchronizer per bit before the FSMs. Total latency from input change to pulse/count update is 3 edges. Synchronizer flops reset to 0.
- Undefined: inputs feed the FSMs directly, 1-edge latency. The bench must then drive inputs synchronously.

Decomposition:
- Package parking_pkg holds:
  - gate_state_t enum: IDLE, EN1..EN3, EX1..EX3, RESYNC.
  - gate_evt_t enum: EVT_NONE, EVT_ENTER, EVT_EXIT.
  - Input encodings as localparams: S_CLEAR=2'b00, S_OUTER=2'b10, S_BOTH=2'b11, S_INNER=2'b01.
- Sub-module parking_gate_fsm: one instance per gate via generate. Ports clk, reset, outer, inner, enter_pulse, exit_pulse.
- The top level contains only instantiation, popcount, saturating counter and flags.

Test Plan:
- Reset then gate0 steps 10,11,01,00, one cycle each -> enter_pulse[0] for 1 cycle, car_count 0->1, empty 1->0.
- Gate1 steps 01,11,10,00 with car_count=1 -> exit_pulse[1], car_count=0, empty=1, count_err=0.
- Gate0 steps 10,00 (pedestrian), then 10,11,10,00 (car backs out) -> no pulses, car_count unchanged, FSM back in IDLE.
- Drive 16 entries on gate0, then a 17th -> full=1 at 16, car_count stays 16, count_err=1 and sticky until reset.
- With car_count=5, gate0 entry and gate1 exit complete on the same edge -> both pulses, car_count stays 5. Two simultaneous entries at 5 -> 7.
- Skip-step 10->01 on gate0 -> RESYNC, no event until 00. Reset asserted mid-entry (state EN2) -> car_count=0, no pulse after release.
